// File: rtl/seg7_scan_drive.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous double-buffered loads.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN switches off leading zero digits 3..1.
module seg7_scan_drive #(
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 500
) (
    input  logic        BJ_clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        busy,
    output logic        load_ack,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC);

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } slot_state_t;

    slot_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [15:0]      stage, shadow, shadow_nxt;
    logic [3:0]       stage_dp, shadow_dp, shadow_dp_nxt;
    logic             busy_nxt, fd_nxt, ack_nxt, commit;
    logic             lz_off;
    logic [3:0]       nib_nxt;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // All output registers are loaded from next-cycle values so they line up with cnt/idx.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = idx + 2'd1;
        end
        state_nxt = (cnt_nxt < CNT_GAP) ? ST_GAP : ST_ON;

        commit        = frame_done & busy;
        shadow_nxt    = commit ? stage    : shadow;
        shadow_dp_nxt = commit ? stage_dp : shadow_dp;
        busy_nxt      = load | (busy & ~frame_done);
        fd_nxt        = (cnt_nxt == CNT_LAST) && (idx_nxt == 2'd3);
        ack_nxt       = fd_nxt & busy_nxt;
        nib_nxt       = shadow_nxt[{idx_nxt, 2'b00} +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_off = 1'b0;
        case (idx_nxt)
            2'd3:    lz_off = (shadow_nxt[15:12] == 4'h0)  && !shadow_dp_nxt[3];
            2'd2:    lz_off = (shadow_nxt[15:8]  == 8'h00) && !shadow_dp_nxt[2];
            2'd1:    lz_off = (shadow_nxt[15:4]  == 12'h0) && !shadow_dp_nxt[1];
            default: lz_off = 1'b0;
        endcase
    end
`else
    assign lz_off = 1'b0;
`endif

    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (state_nxt == ST_ON && !lz_off) begin
            an_nxt[idx_nxt] = 1'b0;
            seg_nxt         = hex_to_seg(nib_nxt);
            dp_nxt          = ~shadow_dp_nxt[idx_nxt];
        end
    end

    always_ff @(posedge BJ_clk or posedge rst) begin
        if (rst) begin
            state <= ST_GAP;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge BJ_clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            stage      <= 16'h0000;
            stage_dp   <= 4'h0;
            shadow     <= 16'h0000;
            shadow_dp  <= 4'h0;
            busy       <= 1'b0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shadow     <= shadow_nxt;
            shadow_dp  <= shadow_dp_nxt;
            busy       <= busy_nxt;
            load_ack   <= ack_nxt;
            frame_done <= fd_nxt;
            an_n       <= an_nxt;
            seg_n      <= seg_nxt;
            dp_n       <= dp_nxt;
            if (load) begin
                stage    <= data_in;
                stage_dp <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_drive.sv
// Randomised bench for seg7_scan_drive against a cycle-count based reference model.
module tb_seg7_scan_drive;

    localparam int SCAN_DIV = 8;
    localparam int GAP_CYC  = 2;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        BJ_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [15:0] data_in = 16'h0;
    logic [3:0]  dp_in   = 4'h0;
    logic        load    = 1'b0;
    logic        busy, load_ack, dp_n, frame_done;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;

    always #5 BJ_clk = ~BJ_clk;

    seg7_scan_drive #(.SCAN_DIV(SCAN_DIV), .GAP_CYC(GAP_CYC)) dut (
        .BJ_clk(BJ_clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
        .busy(busy), .load_ack(load_ack), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
        .frame_done(frame_done)
    );

    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk  = 0;
    int n_pass = 0;
    int t;
    int ack_seen;
    logic [15:0] m_stage, m_shadow;
    logic [3:0]  m_stage_dp, m_sdp;
    logic        m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0d)", tag, obs, exp, t);
    endtask

    task automatic model_reset();
        t = 0; m_stage = 16'h0; m_shadow = 16'h0; m_stage_dp = 4'h0; m_sdp = 4'h0; m_busy = 1'b0;
    endtask

    function automatic logic [11:0] exp_disp();
        int pos = t % SCAN_DIV;
        int dig = (t / SCAN_DIV) % 4;
        logic [3:0] an = 4'hF;
        if (pos < GAP_CYC) return {4'hF, 7'h7F, 1'b1};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (m_shadow >> (4 * dig)) == 16'h0 && !m_sdp[dig]) return {4'hF, 7'h7F, 1'b1};
`endif
        an[dig] = 1'b0;
        return {an, seg_lut[m_shadow[dig*4 +: 4]], ~m_sdp[dig]};
    endfunction

    function automatic logic [2:0] exp_ctl();
        logic fd = (t % FRAME == FRAME - 1);
        return {m_busy, fd && m_busy, fd};
    endfunction

    task automatic check_outputs();
        check("disp", 32'({an_n, seg_n, dp_n}), 32'(exp_disp()));
        check("ctl",  32'({busy, load_ack, frame_done}), 32'(exp_ctl()));
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, 32'({an_n, seg_n, dp_n, busy, load_ack, frame_done}),
              32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0}));
    endtask

    task automatic cycle(input logic l, input logic [15:0] d, input logic [3:0] p);
        logic fd;
        load = l; data_in = d; dp_in = p;
        @(posedge BJ_clk);
        fd = (t % FRAME == FRAME - 1);
        if (fd && m_busy) begin
            m_shadow = m_stage; m_sdp = m_stage_dp; m_busy = 1'b0;
        end
        if (l) begin
            m_stage = d; m_stage_dp = p; m_busy = 1'b1;
        end
        t++;
        #1;
        load = 1'b0;
        check_outputs();
        if (load_ack) ack_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (t % FRAME) != phase; i++) cycle(1'b0, 16'h0, 4'h0);
        check("phase", 32'(t % FRAME), 32'(phase));
    endtask

    initial begin
        model_reset();
        ack_seen = 0;
        repeat (3) @(posedge BJ_clk);
        #1 check_reset_values("reset_hold");
        @(negedge BJ_clk) rst = 1'b0;
        check_outputs();

        // free-running scan of zeros
        idle(2 * FRAME);

        // single load mid-frame
        run_to(10);
        cycle(1'b1, 16'h1A8F, 4'b0100);
        idle(2 * FRAME);

        // two loads within one frame, one acknowledge
        run_to(5);
        ack_seen = 0;
        cycle(1'b1, 16'h1111, 4'h0);
        run_to(12);
        cycle(1'b1, 16'h2222, 4'h0);
        idle(FRAME);
        check("acks_two_loads", 32'(ack_seen), 32'd1);

        // load on the boundary cycle while busy
        run_to(8);
        cycle(1'b1, 16'h2222, 4'h0);
        ack_seen = 0;
        run_to(31);
        cycle(1'b1, 16'h3333, 4'h0);
        idle(FRAME + 2);
        check("acks_boundary_load", 32'(ack_seen), 32'd2);

        // asynchronous reset during digit 2 ON with busy
        run_to(12);
        cycle(1'b1, 16'hBEEF, 4'b1010);
        run_to(20);
        check("busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_async");
        model_reset();
        @(posedge BJ_clk);
        #1 check_reset_values("rst_held");
        @(negedge BJ_clk) rst = 1'b0;
        check_outputs();
        idle(2 * FRAME);

        // random loads
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 11) == 0, 16'($urandom), 4'($urandom));
        end
        idle(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg7_scan_drive.md
SEG7_SCAN_DRIVE -- requirements
Module: seg7_scan_drive

Interface
REQ-001 Parameter SCAN_DIV, default 50000: BJ_clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GAP_CYC, default 500: blanking cycles at the start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 BJ_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 dp_in  input  4  decimal point per digit, active-high; bit i belongs to digit i.
REQ-007 load  input  1  single-cycle request to capture data_in and dp_in.
REQ-008 busy  output  1  high while a captured value waits for the frame boundary.
REQ-009 load_ack  output  1  one-cycle pulse when staged data becomes visible.
REQ-010 an_n  output  4  digit anode enables, active-low; bit i drives digit i.
REQ-011 seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp_n  output  1  decimal point segment, active-low.
REQ-013 frame_done  output  1  one-cycle pulse on the last cycle of digit 3's slot.

Function
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; a 2-bit digit index SHALL advance 0->1->2->3->0 on each wrap.
REQ-015 A slot SHALL have two states: GAP while the count is below GAP_CYC, then ON for the rest of the slot.
REQ-016 In GAP the block SHALL drive an_n=4'b1111, seg_n=7'h7F and dp_n=1.
REQ-017 In ON the block SHALL drive low only an_n[index], drive seg_n from the hex decode of the shadow nibble, and drive dp_n=~shadow_dp[index].
REQ-018 The hex decode SHALL be standard active-low; for example 0->7'h40, 1->7'h79, 8->7'h00, F->7'h0E, with A..F shown as A,b,C,d,E,F.
REQ-019 When load is high and busy is low, the block SHALL capture data_in and dp_in into staging registers and set busy on the next cycle.
REQ-020 When load is high and busy is high, the block SHALL overwrite staging (latest value wins), keep busy high, and issue no extra load_ack.
REQ-021 At the frame boundary (the cycle frame_done is high) with busy=1, the block SHALL copy staging into the shadow registers, clear busy and pulse load_ack; the new digit 0 SHALL show the new value.
REQ-022 If load arrives in that same boundary cycle, the older staging SHALL transfer, the new value SHALL enter staging, busy SHALL stay 1, and load_ack SHALL still pulse.
REQ-023 The shadow registers SHALL never change mid-frame; there is no display tearing.
REQ-024 Outputs SHALL be registered; an_n, seg_n and dp_n change only at slot or GAP/ON edges and are glitch-free.

Reset
REQ-025 While rst is high: prescaler=0, index=0, state=GAP, staging=0, shadow=0, shadow_dp=0, busy=0, load_ack=0, frame_done=0, an_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-026 Reset asserted mid-frame or mid-handshake SHALL discard pending staging.
REQ-027 After rst falls, scanning SHALL restart at digit 0 in GAP on the first BJ_clk edge.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN, when defined, SHALL treat digit i (i=3,2,1) as GAP (anode off) during its ON phase if shadow nibbles i..3 are all zero and shadow_dp[i]=0; digit 0 SHALL never be blanked.
REQ-029 Without SEG7_LEADING_ZERO_BLANK_EN every digit SHALL display, including leading zeros.

Verification (SCAN_DIV=8, GAP_CYC=2)
REQ-030 Reset, then run 64 cycles -> an_n walks E,D,B,7; each slot has 2 cycles of an_n=F then 6 cycles active; seg_n=7'h40 throughout ON; frame_done every 32 cycles.
REQ-031 load with data_in=16'h1A8F, dp_in=4'b0100 mid-frame -> busy=1 until the boundary; load_ack pulses with frame_done; next frame shows F,8,A,1 with seg_n 0E,00,08,79 and dp_n=0 only on digit 2.
REQ-032 Two loads (16'h1111 then 16'h2222) in one frame -> one load_ack; display shows 2222; 1111 never appears.
REQ-033 load of 16'h3333 exactly on the frame_done cycle while busy holding 16'h2222 -> 2222 shown this frame; busy stays 1; 3333 shown the following frame with a second load_ack.
REQ-034 rst pulse during digit 2 ON with busy=1 -> outputs reach reset values immediately (asynchronously); busy=0; display shows 0000 afterwards.
REQ-035 With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3 and 2 stay an_n-off during ON; digits 1 and 0 show 5 and 0; with 16'h0000 only digit 0 lights.
